axis_packet_arbiter: RTL and testbench

Two-input, packet-granular round-robin arbiter merging two AXI-Stream sources onto one AXI-Stream output; it is the ingress-side counterpart of `packet_router` and shares one downstream consumer between two requesters. A grant is held from the first beat to the `tlast` beat, so packets are never interleaved. Per-input packet counters, a total beat counter and a status word are readable over a read-only AXI-Lite slave.

---
 rtl/axis_packet_arbiter_pkg.sv | 18 +
 rtl/axis_packet_arbiter_if.sv | 25 ++
 rtl/axis_packet_arbiter_regs.sv | 59 +++++
 rtl/axis_packet_arbiter.sv | 102 ++++++++++
 tb/tb_axis_packet_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types and constants for the two-input packet arbiter.
package axis_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Register index, decoded from araddr[3:2]
  localparam logic [1:0] REG_PKT0   = 2'd0;
  localparam logic [1:0] REG_PKT1   = 2'd1;
  localparam logic [1:0] REG_BEATS  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// Bus bundles: AXI-Stream channel and AXI-Lite read-only channel.
interface axis_if #(parameter int TDATA_WIDTH = 32);
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic                   tvalid;
  logic                   tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

interface axil_rd_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (output araddr, output arvalid, input arready,
                  input rdata, input rresp, input rvalid, output rready);
  modport slave  (input araddr, input arvalid, output arready,
                  output rdata, output rresp, output rvalid, input rready);
endinterface

// File: rtl/axis_packet_arbiter_regs.sv
// Generic read-only AXI-Lite slave exposing four 32-bit registers.
module axilite_status_regs
  import axis_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] reg0_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] reg3_i,
  axil_rd_if.slave    s_axil
);

  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  // Address decode: word-aligned offsets 0x0..0xC are legal, all else SLVERR
  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_SLVERR;
    if (s_axil.araddr[31:4] == '0 && s_axil.araddr[1:0] == 2'b00) begin
      rresp_d = RESP_OKAY;
      case (s_axil.araddr[3:2])
        REG_PKT0:  rdata_d = reg0_i;
        REG_PKT1:  rdata_d = reg1_i;
        REG_BEATS: rdata_d = reg2_i;
        default:   rdata_d = reg3_i;
      endcase
    end
  end

  // Read handshake: capture on AR handshake, hold response until R handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else if (s_axil.arvalid && arready_q) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b1;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end else if (rvalid_q && s_axil.rready) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end else if (!rvalid_q) begin
      arready_q <= 1'b1;
    end
  end

  assign s_axil.arready = arready_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;

endmodule

// File: rtl/axis_packet_arbiter.sv
// Two-input packet-granular round-robin AXI-Stream arbiter with status counters.
module axis_packet_arbiter
  import axis_arbiter_pkg::*;
#(
  parameter int TDATA_WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  axis_if.slave    s0_axis,
  axis_if.slave    s1_axis,
  axis_if.master   m_axis,
  axil_rd_if.slave s_axil
);

  state_e                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic [31:0]            pkt_count0_q, pkt_count1_q, beat_count_q;

  logic                   busy;
  logic                   sel_tvalid;
  logic                   sel_tlast;
  logic [TDATA_WIDTH-1:0] sel_tdata;
  logic                   xfer;

  assign busy       = (state_q == ST_BUSY);
  assign sel_tvalid = grant_q ? s1_axis.tvalid : s0_axis.tvalid;
  assign sel_tlast  = grant_q ? s1_axis.tlast  : s0_axis.tlast;
  assign sel_tdata  = grant_q ? s1_axis.tdata  : s0_axis.tdata;
  assign xfer       = busy && sel_tvalid && m_axis.tready;

  // Output mux: only the granted source sees downstream ready while busy
  assign m_axis.tvalid  = busy && sel_tvalid;
  assign m_axis.tlast   = sel_tlast;
  assign m_axis.tdata   = sel_tdata;
  assign s0_axis.tready = busy && !grant_q && m_axis.tready;
  assign s1_axis.tready = busy &&  grant_q && m_axis.tready;

  // Next-state: pick a requester in IDLE, release the grant on the tlast beat
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (s0_axis.tvalid && s1_axis.tvalid) begin
          grant_d = ~last_grant_q;
          state_d = ST_BUSY;
        end else if (s0_axis.tvalid) begin
          grant_d = 1'b0;
          state_d = ST_BUSY;
        end else if (s1_axis.tvalid) begin
          grant_d = 1'b1;
          state_d = ST_BUSY;
        end
      end
      default: begin
        if (xfer && sel_tlast) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end
      end
    endcase
  end

  // Arbiter state register; last_grant starts at 1 so s0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Traffic counters, free-running modulo 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count0_q <= '0;
      pkt_count1_q <= '0;
      beat_count_q <= '0;
    end else if (xfer) begin
      beat_count_q <= beat_count_q + 32'd1;
      if (sel_tlast && !grant_q) pkt_count0_q <= pkt_count0_q + 32'd1;
      if (sel_tlast &&  grant_q) pkt_count1_q <= pkt_count1_q + 32'd1;
    end
  end

  axilite_status_regs u_regs (
    .clk    (clk),
    .reset  (reset),
    .reg0_i (pkt_count0_q),
    .reg1_i (pkt_count1_q),
    .reg2_i (beat_count_q),
    .reg3_i ({30'b0, busy, grant_q}),
    .s_axil (s_axil)
  );

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Randomised scoreboard bench for axis_packet_arbiter.
module tb_axis_packet_arbiter;

  typedef logic [31:0] dq_t[$];
  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axis_if #(.TDATA_WIDTH(32)) s0 ();
  axis_if #(.TDATA_WIDTH(32)) s1 ();
  axis_if #(.TDATA_WIDTH(32)) m ();
  axil_rd_if axil ();

  axis_packet_arbiter #(.TDATA_WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .s0_axis (s0),
    .s1_axis (s1),
    .m_axis  (m),
    .s_axil  (axil)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  int    mdl_pkt0, mdl_pkt1, mdl_beats;
  bit    mdl_last;
  int    tready_mode = 0;
  bit    chk_s1_only = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
  endtask

  // Downstream ready pattern: constant, random, or alternating
  initial begin
    m.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0:       m.tready = 1'b1;
        1:       m.tready = ($urandom_range(0, 9) < 7);
        default: m.tready = ~m.tready;
      endcase
    end
  end

  // Output monitor: pops the scoreboard on every transfer and checks invariants
  initial begin
    bit prev_last;
    beat_t e;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_last = 1'b0;
      end else begin
        chk("tready_exclusive", 64'(s0.tready & s1.tready), 0);
        chk("tready_implies_m_ready", 64'((s0.tready | s1.tready) & ~m.tready), 0);
        if (prev_last) chk("bubble_after_tlast", 64'(m.tvalid), 0);
        if (chk_s1_only) begin
          chk("bp_s0_tready_low", 64'(s0.tready), 0);
          if (m.tvalid) chk("bp_s1_tready_tracks", 64'(s1.tready), 64'(m.tready));
        end
        prev_last = 1'b0;
        if (m.tvalid && m.tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_beat: got data 0x%0h, required no beat", m.tdata);
          end else begin
            e = exp_q.pop_front();
            chk("out_tdata", 64'(m.tdata), 64'(e.d));
            chk("out_tlast", 64'(m.tlast), 64'(e.l));
          end
          prev_last = m.tlast;
        end
      end
    end
  end

  task automatic drive(input int src, input logic v, input logic [31:0] d, input logic l);
    if (src == 0) begin
      s0.tvalid = v; s0.tdata = d; s0.tlast = l;
    end else begin
      s1.tvalid = v; s1.tdata = d; s1.tlast = l;
    end
  endtask

  task automatic send_pkt(input int src, input dq_t data);
    for (int i = 0; i < data.size(); i++) begin
      int  guard;
      bit  fire;
      guard = 0;
      fire  = 1'b0;
      drive(src, 1'b1, data[i], (i == data.size() - 1));
      while (!fire) begin
        @(negedge clk);
        fire = (src == 0) ? (s0.tvalid && s0.tready) : (s1.tvalid && s1.tready);
        @(posedge clk);
        #1;
        guard++;
        if (!fire && guard > 300) begin
          timeout_fail($sformatf("send_pkt_src%0d", src));
          drive(src, 1'b0, '0, 1'b0);
          return;
        end
      end
    end
    drive(src, 1'b0, '0, 1'b0);
  endtask

  task automatic push_pkt(input dq_t q);
    for (int i = 0; i < q.size(); i++) exp_q.push_back('{d: q[i], l: (i == q.size() - 1)});
  endtask

  // Reference model: whole packets, strict alternation under contention
  task automatic round(input bit u0, input bit u1, input dq_t p0, input dq_t p1);
    if (u0 && u1) begin
      if (mdl_last) begin
        push_pkt(p0); push_pkt(p1); mdl_last = 1'b1;
      end else begin
        push_pkt(p1); push_pkt(p0); mdl_last = 1'b0;
      end
    end else if (u0) begin
      push_pkt(p0); mdl_last = 1'b0;
    end else begin
      push_pkt(p1); mdl_last = 1'b1;
    end
    if (u0) begin mdl_pkt0++; mdl_beats += p0.size(); end
    if (u1) begin mdl_pkt1++; mdl_beats += p1.size(); end
    fork
      if (u0) send_pkt(0, p0);
      if (u1) send_pkt(1, p1);
    join
  endtask

  task automatic gen_pkt(input int len, input logic [31:0] base, input bit rnd, output dq_t q);
    q = {};
    for (int i = 0; i < len; i++) q.push_back(rnd ? $urandom() : base + 32'(i));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(posedge clk);
      g++;
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic axil_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    int g;
    d = 32'hDEAD_BEEF;
    r = 2'b11;
    axil.araddr  = addr;
    axil.arvalid = 1'b1;
    g = 0;
    forever begin
      @(negedge clk);
      if (axil.arready) break;
      g++;
      if (g > 100) begin
        timeout_fail("axil_arready");
        axil.arvalid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    axil.arvalid = 1'b0;
    axil.rready  = 1'b1;
    g = 0;
    forever begin
      @(negedge clk);
      if (axil.rvalid) begin
        d = axil.rdata;
        r = axil.rresp;
        break;
      end
      g++;
      if (g > 100) begin
        timeout_fail("axil_rvalid");
        axil.rready = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    axil.rready = 1'b0;
  endtask

  task automatic chk_reg(input string nm, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axil_read(addr, d, r);
    chk({nm, "_rdata"}, 64'(d), 64'(exp));
    chk({nm, "_rresp"}, 64'(r), 64'(2'b00));
  endtask

  task automatic chk_all_regs(input string tag);
    chk_reg({tag, "_pkt0"}, 32'h0, 32'(mdl_pkt0));
    chk_reg({tag, "_pkt1"}, 32'h4, 32'(mdl_pkt1));
    chk_reg({tag, "_beats"}, 32'h8, 32'(mdl_beats));
    chk_reg({tag, "_status"}, 32'hC, {30'b0, 1'b0, mdl_last});
  endtask

  initial begin
    dq_t p0, p1, empty;
    logic [31:0] d, pre;
    logic [1:0]  r;
    int cnt;
    empty = {};

    reset = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    axil.araddr = '0; axil.arvalid = 1'b0; axil.rready = 1'b0;
    mdl_pkt0 = 0; mdl_pkt1 = 0; mdl_beats = 0; mdl_last = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s0_tready", 64'(s0.tready), 0);
    chk("rst_s1_tready", 64'(s1.tready), 0);
    chk("rst_m_tvalid", 64'(m.tvalid), 0);
    chk("rst_arready", 64'(axil.arready), 0);
    chk("rst_rvalid", 64'(axil.rvalid), 0);
    chk("rst_rdata", 64'(axil.rdata), 0);
    chk("rst_rresp", 64'(axil.rresp), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single source packet
    gen_pkt(4, 32'h10, 1'b0, p0);
    round(1'b1, 1'b0, p0, empty);
    drain();
    chk_reg("single_pkt0", 32'h0, 32'd1);
    chk_reg("single_pkt1", 32'h4, 32'd0);
    chk_reg("single_beats", 32'h8, 32'd4);
    chk_reg("single_status", 32'hC, 32'd0);

    // Contention: both sources request together, three times
    for (int k = 0; k < 3; k++) begin
      gen_pkt(3, 32'h100 + 32'(k * 16), 1'b0, p0);
      gen_pkt(3, 32'h200 + 32'(k * 16), 1'b0, p1);
      round(1'b1, 1'b1, p0, p1);
    end
    drain();
    chk_all_regs("contend");

    // Backpressure on an s1 packet with alternating downstream ready
    tready_mode = 2;
    chk_s1_only = 1'b1;
    gen_pkt(8, 32'h300, 1'b0, p1);
    round(1'b0, 1'b1, empty, p1);
    drain();
    chk_s1_only = 1'b0;
    tready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_regs("bp");

    // Snapshot: read beat count on the same edge a beat transfers
    pre = 32'(mdl_beats);
    exp_q.push_back('{d: 32'hABCD_0001, l: 1'b1});
    drive(0, 1'b1, 32'hABCD_0001, 1'b1);
    @(posedge clk);
    #1;
    axil.araddr = 32'h8; axil.arvalid = 1'b1; axil.rready = 1'b0;
    @(negedge clk);
    chk("snap_arready", 64'(axil.arready), 1);
    chk("snap_beat_fires", 64'(m.tvalid & m.tready), 1);
    @(posedge clk);
    #1;
    axil.arvalid = 1'b0;
    drive(0, 1'b0, '0, 1'b0);
    mdl_pkt0++; mdl_beats++; mdl_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rvalid", 64'(axil.rvalid), 1);
      chk("hold_rdata_snapshot", 64'(axil.rdata), 64'(pre));
      chk("hold_arready_low", 64'(axil.arready), 0);
    end
    @(posedge clk);
    #1;
    axil.rready = 1'b1;
    @(posedge clk);
    #1;
    axil.rready = 1'b0;
    @(negedge clk);
    chk("after_r_rvalid", 64'(axil.rvalid), 0);
    chk("after_r_arready", 64'(axil.arready), 1);
    drain();

    // Error responses
    axil_read(32'h10, d, r);
    chk("err10_rdata", 64'(d), 0);
    chk("err10_rresp", 64'(r), 64'(2'b10));
    axil_read(32'h6, d, r);
    chk("err06_rdata", 64'(d), 0);
    chk("err06_rresp", 64'(r), 64'(2'b10));
    chk_all_regs("snap");

    // Reset in the middle of a 5-beat s0 packet
    exp_q.push_back('{d: 32'h500, l: 1'b0});
    exp_q.push_back('{d: 32'h501, l: 1'b0});
    cnt = 0;
    drive(0, 1'b1, 32'h500, 1'b0);
    for (int g = 0; g < 50 && cnt < 2; g++) begin
      bit fire;
      @(negedge clk);
      fire = s0.tvalid && s0.tready;
      @(posedge clk);
      #1;
      if (fire) begin
        cnt++;
        drive(0, 1'b1, 32'h500 + 32'(cnt), 1'b0);
      end
    end
    chk("midrst_two_beats_sent", 64'(cnt), 2);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_s0_tready", 64'(s0.tready), 0);
    chk("midrst_s1_tready", 64'(s1.tready), 0);
    chk("midrst_m_tvalid", 64'(m.tvalid), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 1'b0, '0, 1'b0);
    exp_q = {};
    mdl_pkt0 = 0; mdl_pkt1 = 0; mdl_beats = 0; mdl_last = 1'b1;
    chk_reg("midrst_pkt0", 32'h0, 32'd0);
    chk_reg("midrst_pkt1", 32'h4, 32'd0);
    chk_reg("midrst_beats", 32'h8, 32'd0);
    gen_pkt(4, 32'h600, 1'b0, p1);
    round(1'b0, 1'b1, empty, p1);
    drain();
    chk_all_regs("post_rst");

    // Randomised traffic with random downstream backpressure
    tready_mode = 1;
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = $urandom_range(1, 3);
      gen_pkt($urandom_range(1, 6), 32'h0, 1'b1, p0);
      gen_pkt($urandom_range(1, 6), 32'h0, 1'b1, p1);
      round(sel[0], sel[1], p0, p1);
      if (k % 10 == 9) begin
        drain();
        chk_all_regs("rand");
      end
    end
    drain();
    tready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
